// File: rtl/ureg_responder_pkg.sv
// Shared constants for the user-register responder: address map and
// STATUS / CTRL bit positions.
package ureg_responder_pkg;
  localparam logic [7:0] ADDR_CMD_PUSH = 8'h20;
  localparam logic [7:0] ADDR_STATUS   = 8'h21;
  localparam logic [7:0] ADDR_CYCLE    = 8'h22;
  localparam logic [7:0] ADDR_CTRL     = 8'h23;
  localparam logic [7:0] ADDR_OVF      = 8'h24;

  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;
endpackage

// File: rtl/ureg_cmd_fifo.sv
// First-word-fall-through command FIFO with flush, registered full flag and
// an overflow pulse for pushes dropped while full.
module ureg_cmd_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  input  logic              flush,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              overflow
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt_nxt;
  logic              pop, push_ok;

  assign valid    = (count != '0);
  assign head     = valid ? mem[rptr] : '0;
  // A flush discards any pop offered in the same cycle.
  assign pop      = valid & ready & ~flush;
  assign push_ok  = push & ~flush & (~full | pop);
  assign overflow = push & full & ~pop;

  always_comb begin
    cnt_nxt = count;
    if (push_ok && !pop)      cnt_nxt = count + 1'b1;
    else if (pop && !push_ok) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/ureg_responder.sv
// Target side of the CPU ureg port: GPR bank, cycle counter, control and
// overflow registers, and a command FIFO drained by a downstream sequencer.
module ureg_responder
  import ureg_responder_pkg::*;
#(
  parameter int NUM_GPR    = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_ureg_waddr,
  input  logic [DATA_W-1:0] i_ureg_wdata,
  input  logic              i_ureg_we,
  input  logic [ADDR_W-1:0] i_ureg_raddr,
  output logic [DATA_W-1:0] o_ureg_rdata,
  output logic              o_cmd_valid,
  output logic [DATA_W-1:0] o_cmd_data,
  input  logic              i_cmd_ready,
  output logic              o_fifo_full
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_GPR-1:0][DATA_W-1:0] gpr;
  logic [DATA_W-1:0] cycle, ovf, rd_val;
  logic              ctrl_en, wr_push, wr_ctrl, wr_ovf, flush, overflow;
  logic [CW-1:0]     fifo_count;

  assign wr_push = i_ureg_we && (i_ureg_waddr == ADDR_W'(ADDR_CMD_PUSH));
  assign wr_ctrl = i_ureg_we && (i_ureg_waddr == ADDR_W'(ADDR_CTRL));
  assign wr_ovf  = i_ureg_we && (i_ureg_waddr == ADDR_W'(ADDR_OVF));
  assign flush   = wr_ctrl && i_ureg_wdata[CTRL_FLUSH];

  ureg_cmd_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .push     (wr_push),
    .push_data(i_ureg_wdata),
    .ready    (i_cmd_ready),
    .flush    (flush),
    .valid    (o_cmd_valid),
    .head     (o_cmd_data),
    .count    (fifo_count),
    .full     (o_fifo_full),
    .overflow (overflow)
  );

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)                                           gpr[g] <= '0;
      else if (i_ureg_we && i_ureg_waddr == ADDR_W'(g))     gpr[g] <= i_ureg_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_en <= 1'b0;
      cycle   <= '0;
      ovf     <= '0;
    end else begin
      if (wr_ctrl) ctrl_en <= i_ureg_wdata[CTRL_EN];
      if (ctrl_en) cycle <= cycle + 1'b1;
      // CPU clear beats a concurrent overflow; count saturates.
      if (wr_ovf)                      ovf <= '0;
      else if (overflow && ovf != '1)  ovf <= ovf + 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int g = 0; g < NUM_GPR; g++)
      if (i_ureg_raddr == ADDR_W'(g)) rd_val = gpr[g];
    if (i_ureg_raddr == ADDR_W'(ADDR_STATUS)) begin
      rd_val[7:0]      = 8'(fifo_count);
      rd_val[ST_EMPTY] = ~o_cmd_valid;
      rd_val[ST_FULL]  = o_fifo_full;
    end
    if (i_ureg_raddr == ADDR_W'(ADDR_CYCLE)) rd_val = cycle;
    if (i_ureg_raddr == ADDR_W'(ADDR_CTRL))  rd_val[CTRL_EN] = ctrl_en;
    if (i_ureg_raddr == ADDR_W'(ADDR_OVF))   rd_val = ovf;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_ureg_rdata <= '0;
    else        o_ureg_rdata <= rd_val;
  end
endmodule

// File: doc/ureg_responder.md
Name: ureg_responder

Overview:
- Target side of the CPU user-register (ureg) port. The core issues writes and reads on this port; this block answers them.
- Holds a bank of general user registers, a free-running cycle counter, and a command FIFO.
- CPU pushes 32-bit command words into the FIFO by register writes. A downstream sequencer drains the FIFO through a valid/ready stream.
- Sits beside the core and the instruction/data memories in the top level.

Parameters:
NUM_GPR, 32, number of general-purpose user registers (addresses 0x00..NUM_GPR-1, max 32)
FIFO_DEPTH, 16, command FIFO depth (power of two, 2..128)
DATA_W, 32, register/command data width
ADDR_W, 8, ureg address width

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_ureg_waddr  in  ADDR_W  write address from core
i_ureg_wdata  in  DATA_W  write data from core
i_ureg_we  in  1  write strobe, one cycle per write
i_ureg_raddr  in  ADDR_W  read address from core, sampled every cycle
o_ureg_rdata  out  DATA_W  registered read data
o_cmd_valid  out  1  FIFO head valid
o_cmd_data  out  DATA_W  FIFO head word, first-word-fall-through
i_cmd_ready  in  1  downstream accepts head when valid&ready
o_fifo_full  out  1  FIFO full flag, registered

Behaviour:
- Reset (i_rst=0, async): GPRs, counter, overflow count, control, FIFO pointers/count = 0; o_ureg_rdata=0, o_cmd_valid=0, o_cmd_data=0, o_fifo_full=0.
- Register map:
  - 0x00..NUM_GPR-1: GPR, RW.
  - 0x20 CMD_PUSH: WO; write pushes wdata; reads 0.
  - 0x21 STATUS: RO; [7:0]=count, [8]=empty, [9]=full, others 0.
  - 0x22 CYCLE: RO.
  - 0x23 CTRL: RW; [0]=counter enable; [1]=flush, self-clears, always reads 0.
  - 0x24 OVF: RO; write of any value clears it.
  - Unmapped addresses: reads return 0, writes ignored.
- Read latency is 1 cycle: o_ureg_rdata at edge N+1 reflects the state before edge N for i_ureg_raddr at cycle N. Same-cycle write+read of the same address returns the OLD value.
- Write takes effect at the edge where i_ureg_we=1.
- Cycle counter increments each cycle while CTRL[0]=1. Wraps 0xFFFFFFFF->0.
- FIFO behaviour:
  - Push accepted when not full, or when full with a pop in the same cycle.
  - Pop occurs when o_cmd_valid & i_cmd_ready.
  - Simultaneous push+pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push written at edge N appears on o_cmd_valid/o_cmd_data after edge N (same edge) when the FIFO was empty.
  - o_cmd_data is held stable while valid & !ready.
- Overflow: a push to a full FIFO with no pop is dropped and OVF increments, saturating at 0xFFFFFFFF. A CPU clear of OVF in the same cycle as an overflow sets OVF to 0; the clear wins.
- Flush (write CTRL with bit1=1): at that edge count=0 and pointers=0. A pop in the same cycle is discarded. The flush write carries no FIFO push; CTRL[0] is updated from the same write.
- o_fifo_full is registered and equals (count==FIFO_DEPTH).
- Reset asserted mid-stream clears the FIFO immediately. o_cmd_valid drops asynchronously.

Decomposition:
- Shared package: address constants (ADDR_CMD_PUSH=0x20, ADDR_STATUS=0x21, ADDR_CYCLE=0x22, ADDR_CTRL=0x23, ADDR_OVF=0x24), STATUS/CTRL bit-index constants.
- One sub-module, ureg_cmd_fifo: synchronous FWFT FIFO with push/pop/flush, count, full/empty.
- Decode, GPR bank, counter and read mux stay in ureg_responder.

Test Plan:
- Reset, then write GPR 0x05=0xDEADBEEF; raddr=0x05 the following cycle -> o_ureg_rdata=0xDEADBEEF one cycle later. Same-cycle write/read of 0x05 with 0x12345678 -> old 0xDEADBEEF.
- With i_cmd_ready=0, push 0x11,0x22,0x33 -> o_cmd_valid=1, o_cmd_data=0x11, STATUS=0x003. Then i_cmd_ready=1 for 3 cycles -> 0x11,0x22,0x33 in order, STATUS=0x100.
- Push 17 words with ready=0 -> STATUS=0x210 (full, count 16), o_fifo_full=1, OVF=1. Write OVF -> OVF=0. Push while full with ready=1 -> accepted, count stays 16, OVF stays 0.
- Write CTRL=0x1 and wait 10 cycles -> CYCLE=10±1 per the documented edge timing. Write CTRL=0x0 -> CYCLE frozen. Preload near wrap by running -> wraps to 0.
- With 5 queued words, write CTRL=0x3 -> count=0, o_cmd_valid=0 next cycle, counter enabled, CTRL reads 0x1.
- Assert i_rst=0 mid-stream between edges -> o_cmd_valid, o_ureg_rdata, o_fifo_full go 0 without waiting for a clock edge. Reads of 0x30 and 0x20 -> 0.
